// File: rtl/spi_bus_pkg.sv
// Shared definitions for the SPI man-in-the-middle bus controller:
// state encodings, SPI mode constants and the sample-edge selector.
package spi_bus_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_IDLE      = 3'd1,
    ST_COMM      = 3'd2,
    ST_BUF_START = 3'd3,
    ST_BUF_WAIT  = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  // Modes are encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic sample_on_rise(input logic [1:0] mode);
    case (mode)
      MODE0, MODE3: sample_on_rise = 1'b1;
      MODE1, MODE2: sample_on_rise = 1'b0;
      default:      sample_on_rise = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/spi_shift_lane.sv
// One data line of a chunk: capture shift register, MSB-first injection
// register, bit counter and done flag.
module spi_shift_lane
  import spi_bus_pkg::*;
#(
  parameter int BUF_SIZE = 16,
  parameter int CW       = $clog2(BUF_SIZE + 1)
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                run,
  input  logic                cpha,
  input  logic                line,
  input  logic                sample_edge,
  input  logic                shift_edge,
  input  logic [CW-1:0]       size,
  input  logic [BUF_SIZE-1:0] fake_data,
  output logic [BUF_SIZE-1:0] captured,
  output logic                fake_bit,
  output logic                done
);

  logic [BUF_SIZE-1:0] inj;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       n_q;
  logic [CW-1:0]       gap;
  logic                primed;

  // Left-align the chunk so bit N-1 of fake_data sits at the injection MSB
  assign gap      = CW'(BUF_SIZE) - size;
  assign done     = (cnt == n_q);
  assign fake_bit = primed & inj[BUF_SIZE-1];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      captured <= '0;
      inj      <= '0;
      cnt      <= '0;
      n_q      <= '0;
      primed   <= 1'b0;
    end else if (load) begin
      captured <= '0;
      inj      <= fake_data << gap;
      cnt      <= '0;
      n_q      <= size;
      primed   <= ~cpha;
    end else if (run) begin
      if (sample_edge && !done) begin
        captured <= {captured[BUF_SIZE-2:0], line};
        cnt      <= cnt + CW'(1);
      end
      // With CPHA=1 the first shift edge only presents the first bit
      if (shift_edge) begin
        if (primed) inj <= inj << 1;
        else        primed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_control_mc.sv
// SPI bus man-in-the-middle controller: zero-latency passthrough with
// optional bit injection and chunked capture of the real MISO/MOSI lines.
//   state     | meaning
//   RESET     | held in reset, one cycle after release
//   IDLE      | waiting for a single SS to assert from all-inactive
//   COMM      | communication open, ready for a command
//   BUF_START | chunk lanes loaded, first CPHA=0 bit presented
//   BUF_WAIT  | shifting a chunk until N sample edges or SS drop
//   FINISH    | waiting for the owning SS to deassert
module spi_bus_control_mc
  import spi_bus_pkg::*;
#(
  parameter int BUF_SIZE         = 16,
  parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
  parameter int NUM_SS           = 2,
  parameter int SS_ACTIVE_LOW    = 1
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        miso_in,
  input  logic                        mosi_in,
  input  logic                        sclk_in,
  input  logic [NUM_SS-1:0]           ss_in,
  input  logic                        cpol,
  input  logic                        cpha,
  input  logic                        cmd_next_chunk,
  input  logic                        cmd_finish,
  input  logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size,
  input  logic                        fake_miso_select,
  input  logic                        fake_mosi_select,
  input  logic [BUF_SIZE-1:0]         fake_miso_data,
  input  logic [BUF_SIZE-1:0]         fake_mosi_data,
  output logic                        miso_out,
  output logic                        mosi_out,
  output logic                        sclk_out,
  output logic [NUM_SS-1:0]           ss_out,
  output logic                        comm_active,
  output logic                        bus_ready,
  output logic [$clog2(NUM_SS)-1:0]   active_ss,
  output logic                        chunk_aborted,
  output logic [BUF_SIZE-1:0]         real_miso_data,
  output logic [BUF_SIZE-1:0]         real_mosi_data
);

  localparam int SSW = $clog2(NUM_SS);
  localparam logic [NUM_SS-1:0] SS_IDLE = (SS_ACTIVE_LOW != 0) ? {NUM_SS{1'b1}} : {NUM_SS{1'b0}};

  state_t                      state, state_next;
  logic [1:0]                  sclk_sync, miso_sync, mosi_sync;
  logic [NUM_SS-1:0]           ss_sync1, ss_sync2, ss_act, ss_act_prev;
  logic                        sclk_prev, sclk_rise, sclk_fall;
  logic                        sample_edge, shift_edge;
  logic [1:0]                  mode_q;
  logic [SSW-1:0]              active_q, first_ss;
  logic                        any_ss, owner_active;
  logic                        chunk_load, abort_now, chunk_done, done_miso, done_mosi;
  logic                        fake_miso_bit, fake_mosi_bit;
  logic [CHUNK_SIZE_WIDTH-1:0] size_eff;

  // SS synchronisers reset to the inactive level so reset never looks like a select
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync   <= '0;
      miso_sync   <= '0;
      mosi_sync   <= '0;
      ss_sync1    <= SS_IDLE;
      ss_sync2    <= SS_IDLE;
      sclk_prev   <= 1'b0;
      ss_act_prev <= '0;
    end else begin
      sclk_sync   <= {sclk_sync[0], sclk_in};
      miso_sync   <= {miso_sync[0], miso_in};
      mosi_sync   <= {mosi_sync[0], mosi_in};
      ss_sync1    <= ss_in;
      ss_sync2    <= ss_sync1;
      sclk_prev   <= sclk_sync[1];
      ss_act_prev <= ss_act;
    end
  end

  assign ss_act       = ss_sync2 ^ SS_IDLE;
  assign sclk_rise    = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall    = ~sclk_sync[1] & sclk_prev;
  assign sample_edge  = sample_on_rise(mode_q) ? sclk_rise : sclk_fall;
  assign shift_edge   = sample_on_rise(mode_q) ? sclk_fall : sclk_rise;
  assign owner_active = ss_act[active_q];
  assign any_ss       = |ss_act;
  assign size_eff     = (next_chunk_size > CHUNK_SIZE_WIDTH'(BUF_SIZE)) ?
                        CHUNK_SIZE_WIDTH'(BUF_SIZE) : next_chunk_size;

  always_comb begin
    first_ss = '0;
    for (int i = NUM_SS - 1; i >= 0; i--) begin
      if (ss_act[i]) first_ss = SSW'(i);
    end
  end

  always_comb begin
    state_next = state;
    chunk_load = 1'b0;
    abort_now  = 1'b0;
    case (state)
      ST_RESET: state_next = ST_IDLE;
      ST_IDLE: begin
        if (ss_act_prev == '0 && any_ss) state_next = ST_COMM;
      end
      ST_COMM: begin
        if (!owner_active) begin
          state_next = ST_IDLE;
        end else if (cmd_next_chunk) begin
          state_next = ST_BUF_START;
          chunk_load = 1'b1;
        end else if (cmd_finish) begin
          state_next = ST_FINISH;
        end
      end
      ST_BUF_START: state_next = ST_BUF_WAIT;
      ST_BUF_WAIT: begin
        if (chunk_done) begin
          state_next = ST_COMM;
        end else if (!owner_active) begin
          state_next = ST_IDLE;
          abort_now  = 1'b1;
        end
      end
      ST_FINISH: begin
        if (!owner_active) state_next = ST_IDLE;
      end
      default: state_next = ST_RESET;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RESET;
      active_q      <= '0;
      mode_q        <= MODE0;
      chunk_aborted <= 1'b0;
    end else begin
      state         <= state_next;
      chunk_aborted <= abort_now;
      if (state == ST_IDLE && state_next == ST_COMM) begin
        active_q <= first_ss;
        mode_q   <= {cpol, cpha};
      end
    end
  end

  // Lanes load on entry to BUF_START so the first CPHA=0 bit is visible there
  spi_shift_lane #(.BUF_SIZE(BUF_SIZE), .CW(CHUNK_SIZE_WIDTH)) u_miso_lane (
    .sys_clk(sys_clk), .rst_n(rst_n), .load(chunk_load), .run(state == ST_BUF_WAIT),
    .cpha(mode_q[0]), .line(miso_sync[1]), .sample_edge(sample_edge), .shift_edge(shift_edge),
    .size(size_eff), .fake_data(fake_miso_data), .captured(real_miso_data),
    .fake_bit(fake_miso_bit), .done(done_miso)
  );

  spi_shift_lane #(.BUF_SIZE(BUF_SIZE), .CW(CHUNK_SIZE_WIDTH)) u_mosi_lane (
    .sys_clk(sys_clk), .rst_n(rst_n), .load(chunk_load), .run(state == ST_BUF_WAIT),
    .cpha(mode_q[0]), .line(mosi_sync[1]), .sample_edge(sample_edge), .shift_edge(shift_edge),
    .size(size_eff), .fake_data(fake_mosi_data), .captured(real_mosi_data),
    .fake_bit(fake_mosi_bit), .done(done_mosi)
  );

  assign chunk_done  = done_miso & done_mosi;
  assign active_ss   = active_q;
  assign bus_ready   = (state == ST_IDLE) || (state == ST_COMM);
  assign comm_active = (state == ST_COMM) || (state == ST_BUF_START) ||
                       (state == ST_BUF_WAIT) || (state == ST_FINISH);
  assign sclk_out    = sclk_in;
  assign ss_out      = ss_in;
  assign miso_out    = fake_miso_select ? fake_miso_bit : miso_in;
  assign mosi_out    = fake_mosi_select ? fake_mosi_bit : mosi_in;

endmodule

// File: tb/tb_spi_bus_control_mc.sv
// Directed bench for spi_bus_control_mc: modes 0 and 3, injection, abort,
// command priority, oversize chunks and mid-chunk reset.
module tb_spi_bus_control_mc;

  localparam int H = 8;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        miso_in, mosi_in, sclk_in;
  logic [1:0]  ss_in;
  logic        cpol, cpha, cmd_next_chunk, cmd_finish;
  logic [4:0]  next_chunk_size;
  logic        fake_miso_select, fake_mosi_select;
  logic [15:0] fake_miso_data, fake_mosi_data;
  logic        miso_out, mosi_out, sclk_out;
  logic [1:0]  ss_out;
  logic        comm_active, bus_ready, chunk_aborted;
  logic [0:0]  active_ss;
  logic [15:0] real_miso_data, real_mosi_data;

  int n_pass = 0;
  int n_total = 0;

  spi_bus_control_mc dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .miso_in(miso_in), .mosi_in(mosi_in),
    .sclk_in(sclk_in), .ss_in(ss_in), .cpol(cpol), .cpha(cpha),
    .cmd_next_chunk(cmd_next_chunk), .cmd_finish(cmd_finish),
    .next_chunk_size(next_chunk_size), .fake_miso_select(fake_miso_select),
    .fake_mosi_select(fake_mosi_select), .fake_miso_data(fake_miso_data),
    .fake_mosi_data(fake_mosi_data), .miso_out(miso_out), .mosi_out(mosi_out),
    .sclk_out(sclk_out), .ss_out(ss_out), .comm_active(comm_active),
    .bus_ready(bus_ready), .active_ss(active_ss), .chunk_aborted(chunk_aborted),
    .real_miso_data(real_miso_data), .real_mosi_data(real_mosi_data)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required run completion");
    $fatal(1);
  end

  task automatic half(input bit measure, inout logic early, inout int lat);
    for (int k = 1; k <= H; k++) begin
      @(negedge sys_clk);
      if (measure) begin
        if (bus_ready && lat < 0) lat = k;
      end else if (bus_ready) begin
        early = 1'b1;
      end
    end
  endtask

  // Drives n bits MSB-first on the real lines and records miso_out/mosi_out
  // just before each sample edge; lat = cycles from last sample edge to bus_ready.
  task automatic xfer(input int n, input logic ch, input logic [15:0] miso_w, input logic [15:0] mosi_w,
                      output logic [15:0] miso_seen, output logic [15:0] mosi_seen,
                      output logic early, output int lat);
    miso_seen = '0; mosi_seen = '0; early = 1'b0; lat = -1;
    for (int i = n - 1; i >= 0; i--) begin
      if (ch) sclk_in = ~sclk_in;
      miso_in = miso_w[i];
      mosi_in = mosi_w[i];
      half(1'b0, early, lat);
      miso_seen = {miso_seen[14:0], miso_out};
      mosi_seen = {mosi_seen[14:0], mosi_out};
      sclk_in = ~sclk_in;
      half(i == 0, early, lat);
      if (!ch) sclk_in = ~sclk_in;
    end
  endtask

  task automatic start_comm(input int idx, input logic cp, input logic ch);
    cpol = cp; cpha = ch; sclk_in = cp;
    repeat (4) @(negedge sys_clk);
    ss_in = 2'b11;
    ss_in[idx] = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic end_comm();
    ss_in = 2'b11;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic send_cmd(input logic nx, input logic fn, input logic [4:0] sz,
                          input logic [15:0] fmi, input logic [15:0] fmo);
    cmd_next_chunk = nx; cmd_finish = fn; next_chunk_size = sz;
    fake_miso_data = fmi; fake_mosi_data = fmo;
    @(negedge sys_clk);
    cmd_next_chunk = 1'b0; cmd_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    miso_in = 0; mosi_in = 0; sclk_in = 0; ss_in = 2'b11; cpol = 0; cpha = 0;
    cmd_next_chunk = 0; cmd_finish = 0; next_chunk_size = '0;
    fake_miso_select = 0; fake_mosi_select = 0; fake_miso_data = '0; fake_mosi_data = '0;
    repeat (3) @(negedge sys_clk);
    n_total++; if (bus_ready !== 1'b0) $display("FAIL reset_bus_ready: got %b expected 0", bus_ready); else n_pass++;
    n_total++; if ({comm_active, chunk_aborted, active_ss} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {comm_active, chunk_aborted, active_ss}); else n_pass++;
    n_total++; if ({real_miso_data, real_mosi_data} !== 32'h0)
      $display("FAIL reset_data: got %h expected 00000000", {real_miso_data, real_mosi_data}); else n_pass++;
    rst_n = 1'b1;
    @(negedge sys_clk);
    n_total++; if (bus_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus_ready); else n_pass++;
  endtask

  task automatic test_passthrough();
    miso_in = 1; mosi_in = 0; sclk_in = 1; ss_in = 2'b01;
    #1;
    n_total++; if ({miso_out, mosi_out, sclk_out, ss_out} !== 5'b10101)
      $display("FAIL pass_a: got %b expected 10101", {miso_out, mosi_out, sclk_out, ss_out}); else n_pass++;
    miso_in = 0; mosi_in = 1; sclk_in = 0; ss_in = 2'b10;
    #1;
    n_total++; if ({miso_out, mosi_out, sclk_out, ss_out} !== 5'b01010)
      $display("FAIL pass_b: got %b expected 01010", {miso_out, mosi_out, sclk_out, ss_out}); else n_pass++;
    ss_in = 2'b11; miso_in = 1; fake_miso_select = 1;
    #1;
    n_total++; if (miso_out !== 1'b0) $display("FAIL pass_fake_idle: got %b expected 0", miso_out); else n_pass++;
    fake_miso_select = 0; miso_in = 0; mosi_in = 0;
    repeat (5) @(negedge sys_clk);
    n_total++; if (comm_active !== 1'b0) $display("FAIL pass_no_start: got %b expected 0", comm_active); else n_pass++;
  endtask

  task automatic test_mode0_inject();
    logic [15:0] ms, mo; logic early; int lat;
    fake_miso_select = 1; fake_mosi_select = 0;
    start_comm(0, 1'b0, 1'b0);
    n_total++; if ({comm_active, bus_ready, active_ss} !== 3'b110)
      $display("FAIL m0_start: got %b expected 110", {comm_active, bus_ready, active_ss}); else n_pass++;
    send_cmd(1, 0, 5'd8, 16'h003C, 16'h0000);
    n_total++; if (bus_ready !== 1'b0) $display("FAIL m0_busy: got %b expected 0", bus_ready); else n_pass++;
    repeat (2) @(negedge sys_clk);
    xfer(8, 1'b0, 16'h00FF, 16'h00A5, ms, mo, early, lat);
    n_total++; if (ms !== 16'h003C) $display("FAIL m0_miso_inject: got %h expected 003c", ms); else n_pass++;
    n_total++; if (mo !== 16'h00A5) $display("FAIL m0_mosi_pass: got %h expected 00a5", mo); else n_pass++;
    n_total++; if (early !== 1'b0) $display("FAIL m0_ready_early: got %b expected 0", early); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL m0_ready_latency: got %0d expected 4", lat); else n_pass++;
    n_total++; if (real_mosi_data !== 16'h00A5) $display("FAIL m0_real_mosi: got %h expected 00a5", real_mosi_data); else n_pass++;
    n_total++; if (real_miso_data !== 16'h00FF) $display("FAIL m0_real_miso: got %h expected 00ff", real_miso_data); else n_pass++;
    end_comm();
    n_total++; if ({comm_active, bus_ready} !== 2'b01)
      $display("FAIL m0_end: got %b expected 01", {comm_active, bus_ready}); else n_pass++;
    fake_miso_select = 0;
  endtask

  task automatic test_mode3();
    logic [15:0] ms, mo; logic early; int lat;
    fake_mosi_select = 1;
    start_comm(0, 1'b1, 1'b1);
    send_cmd(1, 0, 5'd12, 16'h0000, 16'h05A3);
    repeat (2) @(negedge sys_clk);
    xfer(12, 1'b1, 16'h00F0, 16'h0ABC, ms, mo, early, lat);
    n_total++; if (mo !== 16'h05A3) $display("FAIL m3_mosi_inject: got %h expected 05a3", mo); else n_pass++;
    n_total++; if (ms !== 16'h00F0) $display("FAIL m3_miso_pass: got %h expected 00f0", ms); else n_pass++;
    n_total++; if (real_mosi_data !== 16'h0ABC) $display("FAIL m3_real_mosi: got %h expected 0abc", real_mosi_data); else n_pass++;
    n_total++; if (real_miso_data !== 16'h00F0) $display("FAIL m3_real_miso: got %h expected 00f0", real_miso_data); else n_pass++;
    n_total++; if ({early, lat == 4} !== 2'b01) $display("FAIL m3_ready: got early=%b lat=%0d expected early=0 lat=4", early, lat); else n_pass++;
    end_comm();
    fake_mosi_select = 0;
  endtask

  task automatic test_abort();
    logic [15:0] ms, mo; logic early; int lat; int pulses;
    start_comm(1, 1'b0, 1'b0);
    ss_in = 2'b00;
    repeat (4) @(negedge sys_clk);
    n_total++; if ({comm_active, active_ss} !== 2'b11)
      $display("FAIL ab_owner: got %b expected 11", {comm_active, active_ss}); else n_pass++;
    send_cmd(1, 0, 5'd8, 16'h0000, 16'h0000);
    repeat (2) @(negedge sys_clk);
    xfer(5, 1'b0, 16'h0005, 16'h001A, ms, mo, early, lat);
    ss_in = 2'b10;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      if (chunk_aborted) pulses++;
    end
    n_total++; if (pulses !== 1) $display("FAIL ab_pulse: got %0d cycles expected 1", pulses); else n_pass++;
    n_total++; if ({comm_active, bus_ready} !== 2'b01)
      $display("FAIL ab_idle: got %b expected 01", {comm_active, bus_ready}); else n_pass++;
    n_total++; if (real_mosi_data !== 16'h001A) $display("FAIL ab_mosi_partial: got %h expected 001a", real_mosi_data); else n_pass++;
    n_total++; if (real_miso_data !== 16'h0005) $display("FAIL ab_miso_partial: got %h expected 0005", real_miso_data); else n_pass++;
    end_comm();
    n_total++; if (comm_active !== 1'b0) $display("FAIL ab_no_restart: got %b expected 0", comm_active); else n_pass++;
  endtask

  task automatic test_both_cmds();
    start_comm(0, 1'b0, 1'b0);
    send_cmd(1, 1, 5'd0, 16'h0000, 16'h0000);
    n_total++; if ({comm_active, bus_ready} !== 2'b10)
      $display("FAIL both_c1: got %b expected 10", {comm_active, bus_ready}); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (bus_ready !== 1'b0) $display("FAIL both_c2: got %b expected 0", bus_ready); else n_pass++;
    @(negedge sys_clk);
    n_total++; if ({comm_active, bus_ready} !== 2'b11)
      $display("FAIL both_back: got %b expected 11", {comm_active, bus_ready}); else n_pass++;
    n_total++; if (real_mosi_data !== 16'h0000) $display("FAIL both_cleared: got %h expected 0000", real_mosi_data); else n_pass++;
    send_cmd(0, 1, 5'd0, 16'h0000, 16'h0000);
    repeat (3) @(negedge sys_clk);
    n_total++; if ({comm_active, bus_ready} !== 2'b10)
      $display("FAIL finish_hold: got %b expected 10", {comm_active, bus_ready}); else n_pass++;
    end_comm();
    n_total++; if ({comm_active, bus_ready} !== 2'b01)
      $display("FAIL finish_idle: got %b expected 01", {comm_active, bus_ready}); else n_pass++;
    send_cmd(1, 0, 5'd8, 16'h0000, 16'h0000);
    repeat (2) @(negedge sys_clk);
    n_total++; if ({comm_active, bus_ready} !== 2'b01)
      $display("FAIL idle_cmd_ignored: got %b expected 01", {comm_active, bus_ready}); else n_pass++;
  endtask

  task automatic test_oversize();
    logic [15:0] ms, mo; logic early; int lat;
    start_comm(0, 1'b0, 1'b0);
    send_cmd(1, 0, 5'd17, 16'h0000, 16'h0000);
    repeat (2) @(negedge sys_clk);
    xfer(16, 1'b0, 16'h1234, 16'hBEEF, ms, mo, early, lat);
    n_total++; if ({early, lat == 4} !== 2'b01) $display("FAIL ovr_ready: got early=%b lat=%0d expected early=0 lat=4", early, lat); else n_pass++;
    n_total++; if (real_mosi_data !== 16'hBEEF) $display("FAIL ovr_mosi: got %h expected beef", real_mosi_data); else n_pass++;
    n_total++; if (real_miso_data !== 16'h1234) $display("FAIL ovr_miso: got %h expected 1234", real_miso_data); else n_pass++;
    end_comm();
  endtask

  task automatic test_reset_mid();
    logic [15:0] ms, mo; logic early; int lat; int pulses;
    fake_mosi_select = 1;
    start_comm(1, 1'b0, 1'b0);
    send_cmd(1, 0, 5'd8, 16'h00FF, 16'h00FF);
    repeat (2) @(negedge sys_clk);
    xfer(3, 1'b0, 16'h0007, 16'h0005, ms, mo, early, lat);
    mosi_in = 0;
    #1;
    n_total++; if (mosi_out !== 1'b1) $display("FAIL rm_fake_before: got %b expected 1", mosi_out); else n_pass++;
    @(negedge sys_clk);
    rst_n = 1'b0; mosi_in = 1; ss_in = 2'b11;
    #1;
    n_total++; if ({comm_active, bus_ready, chunk_aborted, active_ss, mosi_out} !== 5'b00000)
      $display("FAIL rm_outputs: got %b expected 00000", {comm_active, bus_ready, chunk_aborted, active_ss, mosi_out}); else n_pass++;
    n_total++; if ({real_miso_data, real_mosi_data} !== 32'h0)
      $display("FAIL rm_data: got %h expected 00000000", {real_miso_data, real_mosi_data}); else n_pass++;
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
    n_total++; if (bus_ready !== 1'b1) $display("FAIL rm_ready: got %b expected 1", bus_ready); else n_pass++;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      if (chunk_aborted) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL rm_no_abort: got %0d expected 0", pulses); else n_pass++;
    fake_mosi_select = 0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_mode0_inject();
    test_mode3();
    test_abort();
    test_both_cmds();
    test_oversize();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
